// File: rtl/count_tracker.sv
// count_tracker: watches a WIDTH-bit up/down counter and checks every count step.
// It also flags wrap/threshold events and extends the count with a wrap-tracking position.
module count_tracker #(
  parameter int WIDTH     = 4,
  parameter int EXT_WIDTH = 8,
  parameter int ERR_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cnt_rst,
  input  logic                       load_en,
  input  logic [WIDTH-1:0]           load_value,
  input  logic                       up_down,
  input  logic [WIDTH-1:0]           count,
  input  logic [WIDTH-1:0]           threshold,
  input  logic                       clear,
  output logic [EXT_WIDTH+WIDTH-1:0] ext_pos,
  output logic                       wrap_up,
  output logic                       wrap_down,
  output logic                       thr_hit,
  output logic                       step_err,
  output logic [ERR_WIDTH-1:0]       err_cnt
);

  localparam logic [WIDTH-1:0]     CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0]     CNT_MAX = '1;
  localparam logic [EXT_WIDTH-1:0] EXT_ONE = EXT_WIDTH'(1);
  localparam logic [ERR_WIDTH-1:0] ERR_ONE = ERR_WIDTH'(1);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;

  logic                 valid_q, valid_d;
  logic                 cnt_rst_q, cnt_rst_d;
  logic                 load_en_q, load_en_d;
  logic [WIDTH-1:0]     load_value_q, load_value_d;
  logic                 up_down_q, up_down_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [EXT_WIDTH-1:0] ext_hi_q, ext_hi_d;
  logic [WIDTH-1:0]     cnt_lo_q, cnt_lo_d;
  logic                 wrap_up_q, wrap_up_d;
  logic                 wrap_down_q, wrap_down_d;
  logic                 thr_hit_q, thr_hit_d;
  logic                 step_err_q, step_err_d;
  logic [ERR_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0]     exp_count;
  logic                 mismatch;
  logic                 step_up;
  logic                 step_dn;

  // Replay the counter's own priority on last cycle's controls and count.
  always_comb begin
    exp_count = prev_q - CNT_ONE;
    if (cnt_rst_q) begin
      exp_count = '0;
    end else if (load_en_q) begin
      exp_count = load_value_q;
    end else if (up_down_q) begin
      exp_count = prev_q + CNT_ONE;
    end
  end

  assign mismatch = valid_q && (count != exp_count);
  assign step_up  = !cnt_rst_q && !load_en_q && up_down_q;
  assign step_dn  = !cnt_rst_q && !load_en_q && !up_down_q;

  always_comb begin
    valid_d      = 1'b1;
    cnt_rst_d    = cnt_rst;
    load_en_d    = load_en;
    load_value_d = load_value;
    up_down_d    = up_down;
    prev_d       = count;
    ext_hi_d     = ext_hi_q;
    cnt_lo_d     = cnt_lo_q;
    wrap_up_d    = 1'b0;
    wrap_down_d  = 1'b0;
    thr_hit_d    = 1'b0;
    step_err_d   = step_err_q;
    err_cnt_d    = err_cnt_q;

    // With valid_q low this edge only primes the history registers.
    if (valid_q) begin
      cnt_lo_d  = count;
      thr_hit_d = (count == threshold) && (count != prev_q);
      if (mismatch) begin
        step_err_d = 1'b1;
        if (clear) begin
          err_cnt_d = ERR_ONE;
        end else if (err_cnt_q != ERR_MAX) begin
          err_cnt_d = err_cnt_q + ERR_ONE;
        end
      end else begin
        if (clear) begin
          step_err_d = 1'b0;
          err_cnt_d  = '0;
        end
        wrap_up_d   = step_up && (prev_q == CNT_MAX);
        wrap_down_d = step_dn && (prev_q == '0);
        if (cnt_rst_q || load_en_q) begin
          ext_hi_d = '0;
        end else if (wrap_up_d) begin
          ext_hi_d = ext_hi_q + EXT_ONE;
        end else if (wrap_down_d) begin
          ext_hi_d = ext_hi_q - EXT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      cnt_rst_q    <= 1'b0;
      load_en_q    <= 1'b0;
      load_value_q <= '0;
      up_down_q    <= 1'b0;
      prev_q       <= '0;
      ext_hi_q     <= '0;
      cnt_lo_q     <= '0;
      wrap_up_q    <= 1'b0;
      wrap_down_q  <= 1'b0;
      thr_hit_q    <= 1'b0;
      step_err_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      cnt_rst_q    <= cnt_rst_d;
      load_en_q    <= load_en_d;
      load_value_q <= load_value_d;
      up_down_q    <= up_down_d;
      prev_q       <= prev_d;
      ext_hi_q     <= ext_hi_d;
      cnt_lo_q     <= cnt_lo_d;
      wrap_up_q    <= wrap_up_d;
      wrap_down_q  <= wrap_down_d;
      thr_hit_q    <= thr_hit_d;
      step_err_q   <= step_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign ext_pos   = {ext_hi_q, cnt_lo_q};
  assign wrap_up   = wrap_up_q;
  assign wrap_down = wrap_down_q;
  assign thr_hit   = thr_hit_q;
  assign step_err  = step_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_count_tracker.sv
// Directed bench for count_tracker: the bench plays the counter itself, can force
// illegal count values, and compares all outputs against hand-computed values.
module tb_count_tracker;

  localparam int WIDTH     = 4;
  localparam int EXT_WIDTH = 8;
  localparam int ERR_WIDTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnt_rst = 1'b0;
  logic        load_en = 1'b0;
  logic [3:0]  load_value = '0;
  logic        up_down = 1'b0;
  logic [3:0]  count = '0;
  logic [3:0]  threshold = 4'd9;
  logic        clear = 1'b0;
  logic [11:0] ext_pos;
  logic        wrap_up;
  logic        wrap_down;
  logic        thr_hit;
  logic        step_err;
  logic [7:0]  err_cnt;
  logic [23:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        rn;
    logic        cr;
    logic        le;
    logic [3:0]  lv;
    logic        ud;
    logic        clr;
    logic        fen;
    logic [3:0]  fval;
    logic [23:0] exp;
  } row_t;

  count_tracker #(
    .WIDTH(WIDTH),
    .EXT_WIDTH(EXT_WIDTH),
    .ERR_WIDTH(ERR_WIDTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cnt_rst(cnt_rst),
    .load_en(load_en),
    .load_value(load_value),
    .up_down(up_down),
    .count(count),
    .threshold(threshold),
    .clear(clear),
    .ext_pos(ext_pos),
    .wrap_up(wrap_up),
    .wrap_down(wrap_down),
    .thr_hit(thr_hit),
    .step_err(step_err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {ext_pos, wrap_up, wrap_down, thr_hit, step_err, err_cnt};

  function automatic logic [23:0] pk(input logic [11:0] e, input logic wu, input logic wd,
                                     input logic th, input logic se, input logic [7:0] ec);
    return {e, wu, wd, th, se, ec};
  endfunction

  function automatic row_t mk(input logic rn, input logic cr, input logic le, input logic [3:0] lv,
                              input logic ud, input logic clr, input logic fen,
                              input logic [3:0] fval, input logic [23:0] exp);
    row_t r;
    r.rn = rn; r.cr = cr; r.le = le; r.lv = lv; r.ud = ud;
    r.clr = clr; r.fen = fen; r.fval = fval; r.exp = exp;
    return r;
  endfunction

  // Drive one cycle; after the edge the bench-side counter steps (or is forced).
  task automatic cycle(input row_t r);
    rst_n      = r.rn;
    cnt_rst    = r.cr;
    load_en    = r.le;
    load_value = r.lv;
    up_down    = r.ud;
    clear      = r.clr;
    @(posedge clk);
    #1;
    if (r.fen)      count = r.fval;
    else if (r.cr)  count = 4'd0;
    else if (r.le)  count = r.lv;
    else if (r.ud)  count = count + 4'd1;
    else            count = count - 4'd1;
  endtask

  task automatic test_reset;
    cycle(mk(0, 1, 0, 0, 0, 0, 0, 0, '0));
    cycle(mk(0, 1, 0, 0, 0, 0, 0, 0, '0));
    n_checks++;
    if (obs !== 24'h0) begin
      n_fail++;
      $display("FAIL reset: got %h expected %h", obs, 24'h0);
    end
  endtask

  task automatic test_count_up;
    int n_wrap;
    logic [23:0] exp;
    n_wrap = 0;
    cycle(mk(1, 1, 0, 0, 1, 0, 0, 0, '0));
    n_checks++;
    if (obs !== 24'h0) begin
      n_fail++;
      $display("FAIL priming: got %h expected %h", obs, 24'h0);
    end
    for (int j = 1; j <= 20; j++) begin
      cycle(mk(1, 0, 0, 0, 1, 0, 0, 0, '0));
      exp = pk(12'(j - 1), (j - 1) == 16, 1'b0, (j - 1) == 9, 1'b0, 8'd0);
      if (wrap_up === 1'b1) n_wrap++;
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL count_up[%0d]: got %h expected %h", j, obs, exp);
      end
    end
    n_checks++;
    if (n_wrap != 1) begin
      n_fail++;
      $display("FAIL wrap_up_count: got %0d expected 1", n_wrap);
    end
    n_checks++;
    if (ext_pos !== 12'h013) begin
      n_fail++;
      $display("FAIL ext_final: got %h expected 013", ext_pos);
    end
  endtask

  task automatic test_wrap_down;
    row_t rows[5];
    rows[0] = mk(1, 0, 1, 0, 0, 0, 0, 0, pk(12'h014, 0, 0, 0, 0, 0));
    rows[1] = mk(1, 0, 0, 0, 0, 0, 0, 0, pk(12'h000, 0, 0, 0, 0, 0));
    rows[2] = mk(1, 0, 0, 0, 0, 0, 0, 0, pk(12'hFFF, 0, 1, 0, 0, 0));
    rows[3] = mk(1, 0, 0, 0, 0, 0, 0, 0, pk(12'hFFE, 0, 0, 0, 0, 0));
    rows[4] = mk(1, 0, 0, 0, 1, 0, 0, 0, pk(12'hFFD, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      cycle(rows[i]);
      n_checks++;
      if (obs !== rows[i].exp) begin
        n_fail++;
        $display("FAIL wrap_down[%0d]: got %h expected %h", i, obs, rows[i].exp);
      end
    end
  endtask

  task automatic test_threshold;
    row_t rows[8];
    rows[0] = mk(1, 0, 1, 5, 0, 0, 0, 0, pk(12'hFFE, 0, 0, 0, 0, 0));
    rows[1] = mk(1, 0, 0, 0, 1, 0, 0, 0, pk(12'h005, 0, 0, 0, 0, 0));
    rows[2] = mk(1, 0, 0, 0, 1, 0, 0, 0, pk(12'h006, 0, 0, 0, 0, 0));
    rows[3] = mk(1, 0, 0, 0, 1, 0, 0, 0, pk(12'h007, 0, 0, 0, 0, 0));
    rows[4] = mk(1, 0, 0, 0, 1, 0, 0, 0, pk(12'h008, 0, 0, 0, 0, 0));
    rows[5] = mk(1, 0, 1, 9, 0, 0, 0, 0, pk(12'h009, 0, 0, 1, 0, 0));
    rows[6] = mk(1, 0, 1, 9, 0, 0, 0, 0, pk(12'h009, 0, 0, 0, 0, 0));
    rows[7] = mk(1, 0, 0, 0, 1, 0, 0, 0, pk(12'h009, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) begin
      cycle(rows[i]);
      n_checks++;
      if (obs !== rows[i].exp) begin
        n_fail++;
        $display("FAIL threshold[%0d]: got %h expected %h", i, obs, rows[i].exp);
      end
    end
  endtask

  task automatic test_step_err;
    row_t rows[9];
    rows[0] = mk(1, 0, 1, 3, 0, 0, 0, 0, pk(12'h00A, 0, 0, 0, 0, 0));
    rows[1] = mk(1, 0, 0, 0, 1, 0, 1, 7, pk(12'h003, 0, 0, 0, 0, 0));
    rows[2] = mk(1, 0, 0, 0, 1, 0, 1, 2, pk(12'h007, 0, 0, 0, 1, 1));
    rows[3] = mk(1, 0, 0, 0, 1, 0, 1, 2, pk(12'h002, 0, 0, 0, 1, 2));
    rows[4] = mk(1, 0, 0, 0, 1, 0, 1, 2, pk(12'h002, 0, 0, 0, 1, 3));
    rows[5] = mk(1, 0, 0, 0, 1, 0, 0, 0, pk(12'h002, 0, 0, 0, 1, 4));
    rows[6] = mk(1, 0, 0, 0, 1, 1, 1, 6, pk(12'h003, 0, 0, 0, 0, 0));
    rows[7] = mk(1, 0, 0, 0, 1, 1, 0, 0, pk(12'h006, 0, 0, 0, 1, 1));
    rows[8] = mk(1, 0, 0, 0, 1, 0, 0, 0, pk(12'h007, 0, 0, 0, 1, 1));
    for (int i = 0; i < 9; i++) begin
      cycle(rows[i]);
      n_checks++;
      if (obs !== rows[i].exp) begin
        n_fail++;
        $display("FAIL step_err[%0d]: got %h expected %h", i, obs, rows[i].exp);
      end
    end
  endtask

  task automatic test_saturation;
    logic [23:0] exp;
    cycle(mk(1, 0, 0, 0, 1, 1, 1, 5, '0));
    exp = pk(12'h008, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL sat_clear: got %h expected %h", obs, exp);
    end
    for (int i = 1; i <= 300; i++) begin
      cycle(mk(1, 0, 0, 0, 1, 0, 1, 5, '0));
      exp = pk(12'h005, 0, 0, 0, 1, (i > 255) ? 8'd255 : 8'(i));
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL saturate[%0d]: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_mid_reset;
    row_t rows[6];
    rows[0] = mk(1, 0, 1, 10, 0, 1, 0, 0, pk(12'h005, 0, 0, 0, 1, 1));
    rows[1] = mk(1, 0, 0, 0,  1, 0, 0, 0, pk(12'h00A, 0, 0, 0, 1, 1));
    rows[2] = mk(1, 0, 0, 0,  1, 0, 0, 0, pk(12'h00B, 0, 0, 0, 1, 1));
    rows[3] = mk(0, 0, 0, 0,  1, 0, 0, 0, pk(12'h000, 0, 0, 0, 0, 0));
    rows[4] = mk(1, 0, 0, 0,  1, 0, 0, 0, pk(12'h000, 0, 0, 0, 0, 0));
    rows[5] = mk(1, 0, 0, 0,  1, 0, 0, 0, pk(12'h00E, 0, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++) begin
      cycle(rows[i]);
      n_checks++;
      if (obs !== rows[i].exp) begin
        n_fail++;
        $display("FAIL mid_reset[%0d]: got %h expected %h", i, obs, rows[i].exp);
      end
    end
  endtask

  task automatic test_cnt_rst_hold;
    row_t rows[4];
    threshold = 4'd0;
    rows[0] = mk(1, 1, 0, 0, 0, 0, 0, 0, pk(12'h00F, 0, 0, 0, 0, 0));
    rows[1] = mk(1, 1, 0, 0, 0, 0, 0, 0, pk(12'h000, 0, 0, 1, 0, 0));
    rows[2] = mk(1, 1, 0, 0, 0, 0, 0, 0, pk(12'h000, 0, 0, 0, 0, 0));
    rows[3] = mk(1, 0, 0, 0, 1, 0, 0, 0, pk(12'h000, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      cycle(rows[i]);
      n_checks++;
      if (obs !== rows[i].exp) begin
        n_fail++;
        $display("FAIL cnt_rst_hold[%0d]: got %h expected %h", i, obs, rows[i].exp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_count_up;
    test_wrap_down;
    test_threshold;
    test_step_err;
    test_saturation;
    test_mid_reset;
    test_cnt_rst_hold;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_tracker.md
Name: count_tracker

Overview:
- Checker/extension stage placed directly downstream of the 4-bit up/down counter.
- Observes the counter's control inputs and its count output, and checks that every count transition is legal.
- Reports wrap-around events and threshold crossings, and extends the count into a wider signed-free position value for software-visible status.
- Purely observational: it never drives the counter.

Parameters:
- WIDTH, 4, width of the observed count and load value.
- EXT_WIDTH, 8, number of extension bits held above the count in ext_pos.
- ERR_WIDTH, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- cnt_rst  input  1  counter's own active-high reset, as driven to the counter.
- load_en  input  1  counter load enable, as driven to the counter.
- load_value  input  WIDTH  counter load value, as driven to the counter.
- up_down  input  1  counter direction (1 = up, 0 = down), as driven to the counter.
- count  input  WIDTH  counter output.
- threshold  input  WIDTH  compare value for thr_hit; quasi-static.
- clear  input  1  synchronous clear of step_err and err_cnt.
- ext_pos  output  EXT_WIDTH+WIDTH  extended position {wrap extension, count}.
- wrap_up  output  1  one-cycle pulse: legal increment from all-ones to 0.
- wrap_down  output  1  one-cycle pulse: legal decrement from 0 to all-ones.
- thr_hit  output  1  one-cycle pulse: count newly equals threshold.
- step_err  output  1  sticky flag: illegal transition seen.
- err_cnt  output  ERR_WIDTH  saturating count of illegal transitions.

Behaviour:
- Sampling: every rising edge, register cnt_rst, load_en, load_value, up_down (the ctl_q set) and count (prev_q). Set valid_q to 1.
- Expected value: at edge N, the count present was produced by ctl_q applied to prev_q. Priority, mirroring the counter:
  - cnt_rst_q -> 0
  - else load_en_q -> load_value_q
  - else up_down_q -> prev_q+1 mod 2^WIDTH
  - else prev_q-1 mod 2^WIDTH
- Checks are performed only when valid_q=1. The first edge after rst_n release only primes the registers; no outputs change on that edge.
- Latency: all outputs are registered and reflect the count observed at edge N after edge N (1 cycle).
- step_err / err_cnt:
  - Mismatch between count and expected sets step_err.
  - Each mismatch increments err_cnt, saturating at 2^ERR_WIDTH-1.
  - clear=1 zeroes both; a mismatch on the same edge wins, giving step_err=1 and err_cnt=1.
- Wrap pulses: asserted only on a matching increment/decrement step, never on a cnt_rst or load step.
  - wrap_up: prev_q=all-ones, count=0.
  - wrap_down: prev_q=0, count=all-ones.
  - The two pulses are mutually exclusive.
- ext_pos:
  - Low WIDTH bits always equal the checked count.
  - Upper EXT_WIDTH bits: cleared on a cnt_rst_q step or a load_en_q step; +1 on wrap_up; -1 on wrap_down, both modulo 2^EXT_WIDTH; otherwise held.
  - On a mismatch, the upper bits are held and the low bits still take count.
- thr_hit: pulses when count==threshold and count!=prev_q. Repeated loads of the threshold value do not re-pulse. Evaluated regardless of mismatch.
- Reset (rst_n=0): clears valid_q, all ctl_q, prev_q, and every output (ext_pos=0, pulses=0, step_err=0, err_cnt=0).
  - Reset mid-sequence discards history; the next post-reset edge is a priming edge.
- cnt_rst asserted for consecutive cycles: each step expects 0, with no wrap pulse and no thr_hit unless count changed into threshold.

Test Plan:
- rst_n low 2 cycles then high, counter reset then up_down=1 for 20 cycles -> no step_err; wrap_up pulses once (15->0); ext_pos reaches 0x013; err_cnt=0.
- Load 0 then down 3 steps -> wrap_down pulses on 0->15; ext_pos goes 0x000, 0xFFF, 0xFFE, 0xFFD.
- threshold=9, up-count from 5 -> thr_hit single pulse one cycle after count=9; load 9 twice in a row -> no second pulse.
- Bench forces count to jump 3->7 with up_down=1 -> step_err=1, err_cnt=1; three more forced errors -> err_cnt=4; clear -> both 0; clear coincident with error -> err_cnt=1.
- Force 300 consecutive errors with ERR_WIDTH=8 -> err_cnt saturates at 255.
- rst_n low mid-count at count=12 -> all outputs 0 the next cycle; first edge after release produces no pulse or error even if count is nonzero.
